// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file geometry and writeback requester indices.
package cpu_pkg;

  localparam int REG_AW   = 3;
  localparam int REG_DW   = 16;
  localparam int NUM_REGS = 8;

  localparam int WB_ALU   = 0;
  localparam int WB_LOAD  = 1;
  localparam int WB_IMM   = 2;
  localparam int WB_SPARE = 3;

endpackage

// File: rtl/wr_onehot_dec.sv
// AW-to-2**AW one-hot decoder with enable; output is all-zero when disabled.
module wr_onehot_dec
  import cpu_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic              en_i,
  input  logic [AW-1:0]     addr_i,
  output logic [2**AW-1:0]  onehot_o
);

  // Raise exactly one row enable for the addressed register
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file write port, with a registered
// one-hot row write-enable stage aligned to address, data and requester id.
module regfile_wr_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  parameter bit R0_RO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*AW-1:0]       req_addr_i,
  input  logic [NREQ*DW-1:0]       req_data_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [2**AW-1:0]         wr_en_o,
  output logic [AW-1:0]            wr_addr_o,
  output logic [DW-1:0]            wr_data_o,
  output logic [$clog2(NREQ)-1:0]  wr_id_o,
  output logic                     busy_o
);

  localparam int IW = $clog2(NREQ);
  localparam int NR = 2**AW;

  logic [IW-1:0]   prio_q, prio_d;
  logic [NREQ-1:0] prio_mask_s, masked_s, search_s, gnt_s;
  logic            gnt_any_s;
  logic [IW-1:0]   gnt_idx_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;
  logic            wr_commit_s;
  logic [NR-1:0]   dec_s;

  logic [NR-1:0]   wr_en_q;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [IW-1:0]   wr_id_q, wr_id_d;
  logic            busy_q, busy_d;

  // Two-pass find-first: requests at or above prio first, else wrap to the lowest
  always_comb begin
    logic found;
    found     = 1'b0;
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      prio_mask_s[i] = (i >= int'(prio_q));
    end
    masked_s = req_i & prio_mask_s;
    search_s = (|masked_s) ? masked_s : req_i;
    if (rst_n && !stall_i && (|req_i)) begin
      for (int i = 0; i < NREQ; i++) begin
        if (search_s[i] && !found) begin
          found     = 1'b1;
          gnt_idx_s = IW'(i);
        end else begin
          found = found;
        end
      end
      gnt_any_s = found;
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  // Expand the winning index into the one-hot grant vector
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      gnt_s[i] = gnt_any_s && (gnt_idx_s == IW'(i));
    end
  end

  assign sel_addr_s  = req_addr_i[gnt_idx_s*AW +: AW];
  assign sel_data_s  = req_data_i[gnt_idx_s*DW +: DW];
  // A write to a read-only r0 completes the handshake but never reaches the array
  assign wr_commit_s = gnt_any_s && !(R0_RO && (sel_addr_s == '0));

  wr_onehot_dec #(.AW(AW)) u_dec (
    .en_i     (wr_commit_s),
    .addr_i   (sel_addr_s),
    .onehot_o (dec_s)
  );

  // Next-state for the priority pointer and the held write descriptor
  always_comb begin
    prio_d    = prio_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_id_d   = wr_id_q;
    busy_d    = |(req_i & ~gnt_s);
    if (gnt_any_s) begin
      prio_d    = (gnt_idx_s == IW'(NREQ-1)) ? '0 : gnt_idx_s + IW'(1);
      wr_addr_d = sel_addr_s;
      wr_data_d = sel_data_s;
      wr_id_d   = gnt_idx_s;
    end else begin
      prio_d    = prio_q;
    end
  end

  // State and output registers; reset discards any pending write at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_id_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= dec_s;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_id_q   <= wr_id_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt_o     = gnt_s;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign wr_id_o   = wr_id_q;
  assign busy_o    = busy_q;

endmodule
